irq_sync_gateway: RTL
=====================

IRQ_SYNC_GATEWAY -- requirements
Module: irq_sync_gateway

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 2, giving the number of interrupt lines (range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (range 2..4).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port irq_in, input, NUM_IRQ bits: asynchronous raw interrupt lines.
REQ-006 SHALL have port edge_mode, input, NUM_IRQ bits: per line, 1 = rising-edge, 0 = level; quasi-static.
REQ-007 SHALL have port irq_pending, output, NUM_IRQ bits: per-line request to the downstream pass-through stage.
REQ-008 SHALL have port claim_valid, input, 1 bit: consumer claims line claim_id.
REQ-009 SHALL have port claim_id, input, $clog2(NUM_IRQ) bits (min 1): line being claimed.
REQ-010 SHALL have port complete_valid, input, 1 bit: consumer finished servicing line complete_id.
REQ-011 SHALL have port complete_id, input, $clog2(NUM_IRQ) bits (min 1): line being completed.

Function
REQ-012 Each irq_in bit SHALL pass through its own SYNC_STAGES-flop synchronizer; there SHALL be no combinational path from irq_in to any output.
REQ-013 Each line SHALL run an independent FSM with states IDLE, PENDING and INFLIGHT; irq_pending[i] SHALL be 1 exactly in PENDING, driven from a flop.
REQ-014 Level mode, IDLE: synchronized level 1 SHALL move the line to PENDING.
REQ-015 Edge mode, IDLE: a synchronized 0->1 transition SHALL move the line to PENDING.
REQ-016 In PENDING the line SHALL stay PENDING regardless of the input level until it is claimed.
REQ-017 A claim to a PENDING line SHALL move it to INFLIGHT on that edge; a claim to an IDLE or INFLIGHT line, or with claim_id >= NUM_IRQ, SHALL be ignored.
REQ-018 A complete to an INFLIGHT line SHALL move it to IDLE; a complete to any other state or out-of-range id SHALL be ignored.
REQ-019 Edge mode: a rising edge seen in PENDING or INFLIGHT SHALL set a per-line missed bit; the missed bit SHALL hold at most one event.
REQ-020 On complete, if missed is set, the line SHALL go directly to PENDING and clear missed; otherwise it SHALL go to IDLE.
REQ-021 Level mode SHALL never set missed; after complete, a still-high level SHALL re-enter PENDING one cycle later via IDLE.
REQ-022 Latency: irq_pending SHALL rise on the (SYNC_STAGES+1)-th rising clock edge after irq_in goes high and is stable.
REQ-023 Claim and complete in the same cycle to different lines SHALL both take effect; to the same line, both are illegal by state, and each SHALL be evaluated against the pre-edge state.
REQ-024 A change of edge_mode on a non-IDLE line SHALL not alter that line's state; it SHALL take effect from the next IDLE.

Reset
REQ-025 Asserting reset SHALL immediately force all synchronizer flops, edge-history flops and missed bits to 0 and all FSMs to IDLE, so irq_pending = 0.
REQ-026 Reset asserted mid-claim SHALL discard INFLIGHT state; after deassertion a high level-mode line SHALL re-pend per REQ-022.
REQ-027 An input already high at reset release SHALL count as a rising edge in edge mode.

Structure
REQ-028 The FSM state encoding (IDLE=0, PENDING=1, INFLIGHT=2) SHALL live in the shared interrupt package together with the width helper for ids.
REQ-029 One sub-module, irq_gateway_line (one synchronizer, FSM and missed bit), SHALL be instantiated NUM_IRQ times; the top SHALL decode the claim and complete ids.

Verification
REQ-030 Level: irq_in[0]=1 with SYNC_STAGES=2 -> irq_pending[0]=1 at edge 3; claim id 0 -> 0 next cycle; complete with the input still high -> 1 two cycles later.
REQ-031 Edge: pulse irq_in[1] once, claim, pulse again during INFLIGHT, complete -> irq_pending[1]=1 on the cycle after complete; a third pulse before that complete is not counted.
REQ-032 Claim id 1 while line 1 is IDLE, and complete id 0 while line 0 is PENDING -> no state change on either line.
REQ-033 Same-cycle claim id 0 and complete id 1 (line 1 INFLIGHT) -> line 0 INFLIGHT and line 1 IDLE on the next edge.
REQ-034 Assert reset asynchronously between clock edges while line 0 is INFLIGHT -> irq_pending = 0 immediately; after release with irq_in[0]=1 in edge mode -> pending after 3 edges.

Source files
------------

// File: rtl/irq_sync_gateway_pkg.sv
`default_nettype none
// ============================================================================
// Module : irq_sync_gateway_pkg
// Brief  : Shared interrupt definitions. Holds the per-line FSM encoding and
//          the helper that sizes claim/complete id ports.
// Rev    : 1.0  initial release
// ============================================================================
package irq_sync_gateway_pkg;

    // Per-line gateway state; encoding is fixed so debug views stay stable
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_INFLIGHT = 2'd2
    } line_state_t;

    // Width of an id able to address n lines, never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_gateway_line.sv
`default_nettype none
// ============================================================================
// Module : irq_gateway_line
// Brief  : One interrupt line: input synchronizer, edge history, missed-edge
//          bit and IDLE/PENDING/INFLIGHT handshake FSM.
// Rev    : 1.0  initial release
// ============================================================================
module irq_gateway_line
    import irq_sync_gateway_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic irq_raw,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_missed;
    logic                   r_mode;
    logic                   r_pending;
    line_state_t            r_state;

    logic w_sync;
    logic w_rise;
    logic w_trigger;
    logic w_busy_rise;

    assign w_sync      = r_sync[SYNC_STAGES-1];
    // r_prev resets to 0, so a line already high at release reads as an edge
    assign w_rise      = w_sync & ~r_prev;
    assign w_trigger   = edge_mode ? w_rise : w_sync;
    // Outside IDLE the mode captured on the last IDLE cycle governs the line
    assign w_busy_rise = r_mode & w_rise;
    assign pending     = r_pending;

    // Shift the raw line through the synchronizer chain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq_raw};
        end
    end

    // Line FSM with edge history, missed-edge memory and registered pending
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_prev    <= 1'b0;
            r_missed  <= 1'b0;
            r_mode    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_prev <= w_sync;
            case (r_state)
                ST_IDLE: begin
                    r_mode <= edge_mode;
                    if (w_trigger) begin
                        r_state   <= ST_PENDING;
                        r_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (w_busy_rise) begin
                        r_missed <= 1'b1;
                    end
                    if (claim) begin
                        r_state   <= ST_INFLIGHT;
                        r_pending <= 1'b0;
                    end
                end
                ST_INFLIGHT: begin
                    if (complete) begin
                        // A held or coincident edge goes straight back to pending
                        r_missed <= 1'b0;
                        if (r_missed || w_busy_rise) begin
                            r_state   <= ST_PENDING;
                            r_pending <= 1'b1;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_pending <= 1'b0;
                        end
                    end else if (w_busy_rise) begin
                        r_missed <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_sync_gateway.sv
`default_nettype none
// ============================================================================
// Module : irq_sync_gateway
// Brief  : Interrupt gateway. Synchronizes NUM_IRQ raw lines, holds each as a
//          pending request until claimed and completed by the consumer.
// Rev    : 1.0  initial release
// ============================================================================
module irq_sync_gateway
    import irq_sync_gateway_pkg::*;
#(
    parameter int NUM_IRQ     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_IRQ-1:0]              irq_in,
    input  logic [NUM_IRQ-1:0]              edge_mode,
    output logic [NUM_IRQ-1:0]              irq_pending,
    input  logic                            claim_valid,
    input  logic [id_width(NUM_IRQ)-1:0]    claim_id,
    input  logic                            complete_valid,
    input  logic [id_width(NUM_IRQ)-1:0]    complete_id
);

    localparam int c_ID_W = id_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] w_claim;
    logic [NUM_IRQ-1:0] w_complete;

    // Only ids below NUM_IRQ decode to a line; anything larger matches nothing
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        assign w_claim[i]    = claim_valid    && (claim_id    == c_ID_W'(i));
        assign w_complete[i] = complete_valid && (complete_id == c_ID_W'(i));

        irq_gateway_line #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_line (
            .clock     (clock),
            .reset     (reset),
            .irq_raw   (irq_in[i]),
            .edge_mode (edge_mode[i]),
            .claim     (w_claim[i]),
            .complete  (w_complete[i]),
            .pending   (irq_pending[i])
        );
    end

endmodule
`default_nettype wire
